fetch_dual: RTL and testbench

//  Dual-issue fetch stage directly upstream of decode. Issues 64-bit bundle reads to instruction

---
 rtl/fetch_dual_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_dual.sv | 128 ++++++++++++
 tb/tb_fetch_dual.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_dual_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
// Queue entries carry one 64-bit bundle plus per-slot valid bits.
package fetch_dual_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [1:0]  PCSRC_SEQ = 2'b00;
  localparam logic [1:0]  PCSRC_BR  = 2'b01;
  localparam logic [1:0]  PCSRC_JMP = 2'b10;

  typedef struct packed {
    logic [31:0] instr1;
    logic [31:0] instr0;
    logic [31:0] pc;
    logic        v1;
    logic        v0;
  } fetch_entry_t;

  // 2'b11 is reserved and behaves as sequential
  function automatic logic is_redirect(input logic [1:0] s);
    return (s == PCSRC_BR) || (s == PCSRC_JMP);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Bundle queue between imem response and decode.
// Flush wins over push; push+pop is legal when full.
module fetch_fifo
  import fetch_dual_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_dual.sv
// Dual-issue fetch: PC, imem request, bundle queue, redirects.
// Decode sees the queue head combinationally, NOP when invalid.
module fetch_dual
  import fetch_dual_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_f,
  output logic [31:0] imem_addr_f,
  input  logic [63:0] imem_rdata_f,
  input  logic        stall_d,
  input  logic [1:0]  pcsrc_d_0,
  input  logic [1:0]  pcsrc_d_1,
  input  logic [31:0] pc_branch_d_0,
  input  logic [31:0] pc_branch_d_1,
  input  logic [31:0] pc_jump_d_0,
  input  logic [31:0] pc_jump_d_1,
  output logic [31:0] instr_d_0,
  output logic [31:0] instr_d_1,
  output logic [31:0] pc_plus_8_d_0,
  output logic [31:0] pc_plus_8_d_1,
  output logic        valid_d_0,
  output logic        valid_d_1
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]  fetch_pc;
  logic [31:0]  fly_pc;
  logic         fly;
  logic         fly_v0;
  logic         skip0;
  logic         take0;
  logic         take1;
  logic         redirect;
  logic         drop;
  logic [31:0]  target;
  logic [AW:0]  count;
  logic [AW:0]  used;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t wdata;

  assign take0 = !stall_d && valid_d_0
              && is_redirect(pcsrc_d_0);
  assign take1 = !stall_d && valid_d_1
              && !(valid_d_0 && is_redirect(pcsrc_d_0))
              && is_redirect(pcsrc_d_1);
  assign redirect = take0 || take1;

  always_comb begin
    target = pc_branch_d_0;
    unique case (1'b1)
      take0: target = (pcsrc_d_0 == PCSRC_BR)
                    ? pc_branch_d_0 : pc_jump_d_0;
      take1: target = (pcsrc_d_1 == PCSRC_BR)
                    ? pc_branch_d_1 : pc_jump_d_1;
      default: ;
    endcase
  end

  assign used        = count + (AW+1)'(fly);
  assign imem_req_f  = reset && !redirect
                    && (used < (AW+1)'(DEPTH));
  assign imem_addr_f = fetch_pc;

  // A response landing in a redirect cycle is wrong-path
  assign drop = redirect;

  assign wdata = '{
    instr1: imem_rdata_f[63:32],
    instr0: imem_rdata_f[31:0],
    pc:     fly_pc,
    v1:     1'b1,
    v0:     fly_v0
  };

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fly && !drop),
    .wdata (wdata),
    .pop   (!stall_d),
    .flush (redirect),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      fly_pc   <= '0;
      fly      <= 1'b0;
      fly_v0   <= 1'b0;
      skip0    <= 1'b0;
    end else begin
      fly <= imem_req_f;
      if (redirect) begin
        fetch_pc <= target & 32'hFFFF_FFF8;
        skip0    <= target[2];
      end else if (imem_req_f) begin
        fetch_pc <= fetch_pc + 32'd8;
        fly_pc   <= fetch_pc;
        fly_v0   <= !skip0;
        skip0    <= 1'b0;
      end
    end
  end

  assign valid_d_0 = !empty && head.v0;
  assign valid_d_1 = !empty && head.v1;

  assign instr_d_0 = valid_d_0 ? head.instr0 : NOP_INSTR;
  assign instr_d_1 = valid_d_1 ? head.instr1 : NOP_INSTR;
  assign pc_plus_8_d_0 = valid_d_0
                       ? head.pc + 32'd8 : '0;
  assign pc_plus_8_d_1 = valid_d_1
                       ? head.pc + 32'd12 : '0;

  a_no_overfill: assert property (
    @(posedge clk) disable iff (!reset)
    used <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_dual.sv
// Directed bench for fetch_dual with a 1-cycle imem model.
// Instruction words encode their address: 0x20100004 + (addr << 14).
module tb_fetch_dual;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_f;
  logic [31:0] imem_addr_f;
  logic [63:0] imem_rdata_f = '0;
  logic        stall_d;
  logic [1:0]  pcsrc_d_0;
  logic [1:0]  pcsrc_d_1;
  logic [31:0] pc_branch_d_0;
  logic [31:0] pc_branch_d_1;
  logic [31:0] pc_jump_d_0;
  logic [31:0] pc_jump_d_1;
  logic [31:0] instr_d_0;
  logic [31:0] instr_d_1;
  logic [31:0] pc_plus_8_d_0;
  logic [31:0] pc_plus_8_d_1;
  logic        valid_d_0;
  logic        valid_d_1;

  int checks = 0;
  int errors = 0;

  fetch_dual #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_f    (imem_req_f),
    .imem_addr_f   (imem_addr_f),
    .imem_rdata_f  (imem_rdata_f),
    .stall_d       (stall_d),
    .pcsrc_d_0     (pcsrc_d_0),
    .pcsrc_d_1     (pcsrc_d_1),
    .pc_branch_d_0 (pc_branch_d_0),
    .pc_branch_d_1 (pc_branch_d_1),
    .pc_jump_d_0   (pc_jump_d_0),
    .pc_jump_d_1   (pc_jump_d_1),
    .instr_d_0     (instr_d_0),
    .instr_d_1     (instr_d_1),
    .pc_plus_8_d_0 (pc_plus_8_d_0),
    .pc_plus_8_d_1 (pc_plus_8_d_1),
    .valid_d_0     (valid_d_0),
    .valid_d_1     (valid_d_1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h20100004 + (a << 14);
  endfunction

  always @(posedge clk) begin
    if (imem_req_f)
      imem_rdata_f <= {word(imem_addr_f + 32'd4), word(imem_addr_f)};
  end

  task automatic test_reset();
    reset = 1'b0;
    stall_d = 1'b0;
    pcsrc_d_0 = 2'b00;
    pcsrc_d_1 = 2'b00;
    pc_branch_d_0 = '0;
    pc_branch_d_1 = '0;
    pc_jump_d_0 = '0;
    pc_jump_d_1 = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req_f !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req_f); end
    checks++; if ({valid_d_0, valid_d_1} !== 2'b00) begin errors++; $display("FAIL rst_valid got=%b exp=00", {valid_d_0, valid_d_1}); end
    checks++; if ({instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1} !== 128'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", {instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1}); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({imem_req_f, imem_addr_f} !== {1'b1, 32'h0}) begin errors++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req_f, imem_addr_f); end
    @(negedge clk); #1;
    checks++; if (valid_d_0 !== 1'b0) begin errors++; $display("FAIL first_lat got=%b exp=0", valid_d_0); end
    checks++; if (imem_addr_f !== 32'h8) begin errors++; $display("FAIL second_req got=%h exp=8", imem_addr_f); end
    @(negedge clk); #1;
    checks++; if (instr_d_0 !== 32'h20100004) begin errors++; $display("FAIL first_i0 got=%h exp=20100004", instr_d_0); end
    checks++; if (instr_d_1 !== 32'h20110004) begin errors++; $display("FAIL first_i1 got=%h exp=20110004", instr_d_1); end
    checks++; if ({pc_plus_8_d_0, pc_plus_8_d_1} !== {32'd8, 32'd12}) begin errors++; $display("FAIL first_pc got=%h/%h exp=8/c", pc_plus_8_d_0, pc_plus_8_d_1); end
    checks++; if ({valid_d_0, valid_d_1} !== 2'b11) begin errors++; $display("FAIL first_valid got=%b exp=11", {valid_d_0, valid_d_1}); end
  endtask

  task automatic test_stall();
    int reqs = 0;
    stall_d = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (imem_req_f) reqs++;
      checks++; if (pc_plus_8_d_0 !== 32'd8) begin errors++; $display("FAIL stall_head[%0d] got=%h exp=8", i, pc_plus_8_d_0); end
      @(negedge clk);
    end
    #1;
    checks++; if (reqs !== 2) begin errors++; $display("FAIL stall_reqs got=%0d exp=2", reqs); end
    checks++; if (imem_req_f !== 1'b0) begin errors++; $display("FAIL stall_full_req got=%b exp=0", imem_req_f); end
    stall_d = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (pc_plus_8_d_0 !== 32'(8 * i + 8)) begin errors++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, pc_plus_8_d_0, 32'(8 * i + 8)); end
      checks++; if (instr_d_1 !== word(32'(8 * i + 4))) begin errors++; $display("FAIL drain_i1[%0d] got=%h exp=%h", i, instr_d_1, word(32'(8 * i + 4))); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    stall_d = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (imem_req_f !== 1'b0) begin errors++; $display("FAIL br_full_req got=%b exp=0", imem_req_f); end
    stall_d = 1'b0;
    pcsrc_d_0 = 2'b01;
    pc_branch_d_0 = 32'h40;
    #1;
    checks++; if (imem_req_f !== 1'b0) begin errors++; $display("FAIL br_noreq got=%b exp=0", imem_req_f); end
    @(negedge clk);
    pcsrc_d_0 = 2'b00;
    #1;
    checks++; if ({valid_d_0, valid_d_1} !== 2'b00) begin errors++; $display("FAIL br_flush got=%b exp=00", {valid_d_0, valid_d_1}); end
    checks++; if ({imem_req_f, imem_addr_f} !== {1'b1, 32'h40}) begin errors++; $display("FAIL br_req got=%b/%h exp=1/40", imem_req_f, imem_addr_f); end
    @(negedge clk); #1;
    checks++; if (valid_d_0 !== 1'b0) begin errors++; $display("FAIL br_drop got=%b exp=0", valid_d_0); end
    @(negedge clk); #1;
    checks++; if (pc_plus_8_d_0 !== 32'h48) begin errors++; $display("FAIL br_head got=%h exp=48", pc_plus_8_d_0); end
    checks++; if (instr_d_0 !== word(32'h40)) begin errors++; $display("FAIL br_instr got=%h exp=%h", instr_d_0, word(32'h40)); end
    @(negedge clk); #1;
    checks++; if (pc_plus_8_d_0 !== 32'h50) begin errors++; $display("FAIL br_next got=%h exp=50", pc_plus_8_d_0); end
  endtask

  task automatic test_dual_redirect();
    pcsrc_d_0 = 2'b01;
    pc_branch_d_0 = 32'h80;
    pcsrc_d_1 = 2'b10;
    pc_jump_d_1 = 32'h200;
    #1;
    checks++; if (imem_req_f !== 1'b0) begin errors++; $display("FAIL dual_noreq got=%b exp=0", imem_req_f); end
    @(negedge clk);
    pcsrc_d_0 = 2'b00;
    pcsrc_d_1 = 2'b00;
    #1;
    checks++; if ({imem_req_f, imem_addr_f} !== {1'b1, 32'h80}) begin errors++; $display("FAIL dual_req got=%b/%h exp=1/80", imem_req_f, imem_addr_f); end
    checks++; if (valid_d_0 !== 1'b0) begin errors++; $display("FAIL dual_drop got=%b exp=0", valid_d_0); end
    @(negedge clk); #1;
    checks++; if (imem_addr_f !== 32'h88) begin errors++; $display("FAIL dual_seq got=%h exp=88", imem_addr_f); end
    @(negedge clk); #1;
    checks++; if (pc_plus_8_d_0 !== 32'h88) begin errors++; $display("FAIL dual_head got=%h exp=88", pc_plus_8_d_0); end
  endtask

  task automatic test_jump_odd();
    pcsrc_d_1 = 2'b10;
    pc_jump_d_1 = 32'h104;
    #1;
    checks++; if (imem_req_f !== 1'b0) begin errors++; $display("FAIL jmp_noreq got=%b exp=0", imem_req_f); end
    @(negedge clk);
    pcsrc_d_1 = 2'b00;
    #1;
    checks++; if ({imem_req_f, imem_addr_f} !== {1'b1, 32'h100}) begin errors++; $display("FAIL jmp_req got=%b/%h exp=1/100", imem_req_f, imem_addr_f); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({valid_d_0, instr_d_0, pc_plus_8_d_0} !== 65'h0) begin errors++; $display("FAIL jmp_slot0 got=%b/%h/%h exp=0/0/0", valid_d_0, instr_d_0, pc_plus_8_d_0); end
    checks++; if ({valid_d_1, pc_plus_8_d_1} !== {1'b1, 32'h10C}) begin errors++; $display("FAIL jmp_slot1 got=%b/%h exp=1/10c", valid_d_1, pc_plus_8_d_1); end
    checks++; if (instr_d_1 !== word(32'h104)) begin errors++; $display("FAIL jmp_i1 got=%h exp=%h", instr_d_1, word(32'h104)); end
    @(negedge clk); #1;
    checks++; if ({valid_d_0, pc_plus_8_d_0} !== {1'b1, 32'h110}) begin errors++; $display("FAIL jmp_next got=%b/%h exp=1/110", valid_d_0, pc_plus_8_d_0); end
  endtask

  task automatic test_stall_redirect();
    stall_d = 1'b1;
    pcsrc_d_0 = 2'b01;
    pc_branch_d_0 = 32'h300;
    #1;
    checks++; if ({imem_req_f, imem_addr_f} !== {1'b1, 32'h118}) begin errors++; $display("FAIL sr_req got=%b/%h exp=1/118", imem_req_f, imem_addr_f); end
    @(negedge clk); #1;
    checks++; if (imem_addr_f !== 32'h120) begin errors++; $display("FAIL sr_seq got=%h exp=120", imem_addr_f); end
    checks++; if (pc_plus_8_d_0 !== 32'h110) begin errors++; $display("FAIL sr_hold got=%h exp=110", pc_plus_8_d_0); end
    stall_d = 1'b0;
    pcsrc_d_0 = 2'b00;
    @(negedge clk); #1;
    checks++; if (pc_plus_8_d_0 !== 32'h118) begin errors++; $display("FAIL sr_resume got=%h exp=118", pc_plus_8_d_0); end
  endtask

  task automatic test_reset_mid();
    checks++; if ({imem_req_f, imem_addr_f} !== {1'b1, 32'h128}) begin errors++; $display("FAIL rm_req got=%b/%h exp=1/128", imem_req_f, imem_addr_f); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if ({imem_req_f, valid_d_0, valid_d_1} !== 3'b000) begin errors++; $display("FAIL rm_ctrl got=%b exp=000", {imem_req_f, valid_d_0, valid_d_1}); end
    checks++; if ({instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1} !== 128'h0) begin errors++; $display("FAIL rm_data got=%h exp=0", {instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1}); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({imem_req_f, imem_addr_f} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rm_restart got=%b/%h exp=1/0", imem_req_f, imem_addr_f); end
    @(negedge clk); #1;
    checks++; if (valid_d_0 !== 1'b0) begin errors++; $display("FAIL rm_late got=%b exp=0", valid_d_0); end
    @(negedge clk); #1;
    checks++; if ({pc_plus_8_d_0, instr_d_0} !== {32'd8, 32'h20100004}) begin errors++; $display("FAIL rm_head got=%h/%h exp=8/20100004", pc_plus_8_d_0, instr_d_0); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_dual_redirect();
    test_jump_odd();
    test_stall_redirect();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
